// File: rtl/mdu_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: funct codes, FSM states, iteration count.
// ST_DIV exists only when MDU_DIV_EN is defined.
package mdu_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    localparam int unsigned MDU_ITERS = 32;
    localparam int unsigned CNT_W     = $clog2(MDU_ITERS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
`ifdef MDU_DIV_EN
        ST_DIV  = 2'd2,
`endif
        ST_DONE = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative HI/LO multiply/divide unit (radix-2, one 64-bit shift register shared by both ops).
// Divide support is compiled in only when MDU_DIV_EN is defined.
module ex_muldiv
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct_in,
    input  logic [WIDTH-1:0] readData1_in,
    input  logic [WIDTH-1:0] readData2_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_out,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MDU_ITERS - 1);

    mdu_state_e         state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
`ifdef MDU_DIV_EN
    logic               negr_q, negr_d;
    logic               dz_q, dz_d;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_step;
`endif

    logic               op_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;

    assign op_signed = ~funct_in[0];
    assign a_neg     = op_signed & readData1_in[WIDTH-1];
    assign b_neg     = op_signed & readData2_in[WIDTH-1];
    assign mag_a     = a_neg ? -readData1_in : readData1_in;
    assign mag_b     = b_neg ? -readData2_in : readData2_in;

    // Multiply: low half holds the multiplier, high half accumulates; shift right with carry.
    assign mul_sum  = {1'b0, sreg_q[2*WIDTH-1:WIDTH]} + (sreg_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step = {mul_sum, sreg_q[WIDTH-1:1]};

`ifdef MDU_DIV_EN
    // Restoring divide: remainder in the high half, dividend shifts out / quotient shifts in low.
    assign div_trial = sreg_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    assign div_step  = div_trial[WIDTH] ? {sreg_q[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], sreg_q[WIDTH-2:0], 1'b1};
`endif

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sreg_d  = sreg_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
`ifdef MDU_DIV_EN
        negr_d  = negr_q;
        dz_d    = dz_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    unique case (funct_in)
                        FUNCT_MULT, FUNCT_MULTU: begin
                            state_d = ST_MUL;
                            sreg_d  = {{WIDTH{1'b0}}, mag_b};
                            opnd_d  = mag_a;
                            cnt_d   = '0;
                            neg_d   = a_neg ^ b_neg;
                        end
`ifdef MDU_DIV_EN
                        FUNCT_DIV, FUNCT_DIVU: begin
                            state_d = ST_DIV;
                            sreg_d  = {{WIDTH{1'b0}}, mag_a};
                            opnd_d  = mag_b;
                            cnt_d   = '0;
                            neg_d   = a_neg ^ b_neg;
                            negr_d  = a_neg;
                            dz_d    = (readData2_in == '0);
                        end
`endif
                        FUNCT_MTHI: hi_d = readData1_in;
                        FUNCT_MTLO: lo_d = readData1_in;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                sreg_d = mul_step;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d      = ST_DONE;
                    {hi_d, lo_d} = neg_q ? -mul_step : mul_step;
                end
            end
`ifdef MDU_DIV_EN
            ST_DIV: begin
                sreg_d = div_step;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_DONE;
                    // Divide-by-zero keeps the all-ones quotient regardless of operand signs.
                    lo_d = (neg_q && !dz_q) ? -div_step[WIDTH-1:0] : div_step[WIDTH-1:0];
                    hi_d = negr_q ? -div_step[2*WIDTH-1:WIDTH] : div_step[2*WIDTH-1:WIDTH];
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (flush && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            sreg_q  <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
`ifdef MDU_DIV_EN
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sreg_q  <= sreg_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
`ifdef MDU_DIV_EN
            negr_q  <= negr_d;
            dz_q    <= dz_d;
`endif
        end
    end

    assign busy = (state_q == ST_MUL)
`ifdef MDU_DIV_EN
                | (state_q == ST_DIV)
`endif
                ;
    assign done   = (state_q == ST_DONE);
    assign hi_out = hi_q;
    assign lo_out = lo_q;
    assign result_out = (funct_in == FUNCT_MFHI) ? hi_q :
                        (funct_in == FUNCT_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes expected HI/LO, a monitor checks on each done pulse.
// Divide expectations follow MDU_DIV_EN (no-op behaviour when undefined).
module tb_ex_muldiv;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [5:0]  funct_in = '0;
    logic [31:0] rd1 = '0, rd2 = '0;
    logic        busy, done;
    logic [31:0] result_out, hi_out, lo_out;

    ex_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct_in(funct_in),
        .readData1_in(rd1), .readData2_in(rd2), .flush(flush),
        .busy(busy), .done(done), .result_out(result_out),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int unsigned total = 0, bad = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check({mon_e.name, "_hi"}, hi_out, mon_e.hi);
                check({mon_e.name, "_lo"}, lo_out, mon_e.lo);
            end
        end
    end

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        funct_in = f; rd1 = a; rd2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // poke > 0: re-assert start with a different MULTU on that busy cycle; it must be ignored
    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int poke);
        exp_t e;
        int   cyc, guard;
        e.name = name; e.hi = ehi; e.lo = elo;
        sbq.push_back(e);
        issue(f, a, b);
        cyc = 0; guard = 0;
        while (!done && guard < 40) begin
            if (busy) cyc++;
            if (poke != 0 && cyc == poke) begin
                funct_in = FUNCT_MULTU; rd1 = 32'h99; rd2 = 32'h99; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        check({name, "_busy_cycles"}, 32'(cyc), 32'd32);
        check({name, "_done"}, 32'(done), 32'd1);
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
        m_hi = ehi; m_lo = elo;
    endtask

    task automatic flush_op(input string name, input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b, input int at);
        int cyc, guard;
        issue(f, a, b);
        cyc = busy ? 1 : 0; guard = 0;
        while (cyc < at && guard < 40) begin
            @(negedge clk);
            guard++;
            if (busy) cyc++;
        end
        check({name, "_reach"}, 32'(cyc), 32'(at));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_hi"}, hi_out, m_hi);
        check({name, "_lo"}, lo_out, m_lo);
        repeat (40) @(negedge clk);
        check({name, "_hi_later"}, hi_out, m_hi);
    endtask

    initial begin
        int cyc, guard;
        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("multu_max", FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
        run_op("mult_m3x5", FUNCT_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
        funct_in = FUNCT_MFLO; #1;
        check("mflo", result_out, 32'hFFFFFFF1);
        funct_in = FUNCT_MFHI; #1;
        check("mfhi", result_out, 32'hFFFFFFFF);
        funct_in = 6'h20; #1;
        check("mf_other", result_out, 32'd0);

        run_op("mult_7xm6", FUNCT_MULT, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 0);
        run_op("multu_2p16", FUNCT_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 0);
        run_op("mult_min", FUNCT_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0);

        issue(FUNCT_MTHI, 32'h12345678, 32'd0);
        check("mthi_hi", hi_out, 32'h12345678);
        check("mthi_busy", 32'(busy | done), 32'd0);
        issue(FUNCT_MTLO, 32'hCAFEBABE, 32'd0);
        check("mtlo_lo", lo_out, 32'hCAFEBABE);
        check("mtlo_hi", hi_out, 32'h12345678);
        m_hi = 32'h12345678; m_lo = 32'hCAFEBABE;

        flush_op("flush_it10", FUNCT_MULTU, 32'd2, 32'd3, 10);
        flush_op("flush_last", FUNCT_MULTU, 32'd3, 32'd3, 32);

        run_op("start_ignored", FUNCT_MULTU, 32'd4, 32'd5, 32'd0, 32'd20, 5);

`ifdef MDU_DIV_EN
        run_op("div_m7_2", FUNCT_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("divu_7_0", FUNCT_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 0);
        run_op("div_ovf", FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 0);
        run_op("divu_100_7", FUNCT_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        run_op("div_7_m2", FUNCT_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 0);
        run_op("div_m8_0", FUNCT_DIV, 32'hFFFFFFF8, 32'd0, 32'hFFFFFFF8, 32'hFFFFFFFF, 0);
        issue(FUNCT_DIVU, 32'd1000, 32'd3);
`else
        issue(FUNCT_DIVU, 32'd9, 32'd3);
        cyc = 0;
        repeat (40) begin
            if (busy) cyc++;
            @(negedge clk);
        end
        check("divu_noop_busy", 32'(cyc), 32'd0);
        check("divu_noop_hi", hi_out, m_hi);
        check("divu_noop_lo", lo_out, m_lo);
        issue(FUNCT_MULTU, 32'd1000, 32'd3);
`endif
        cyc = busy ? 1 : 0; guard = 0;
        while (cyc < 20 && guard < 40) begin
            @(negedge clk);
            guard++;
            if (busy) cyc++;
        end
        check("rst_mid_reach", 32'(cyc), 32'd20);
        rst_n = 1'b0;
        #1;
        check("rst_mid_hi", hi_out, 32'd0);
        check("rst_mid_lo", lo_out, 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = '0; m_lo = '0;
        run_op("post_rst_4x4", FUNCT_MULTU, 32'd4, 32'd4, 32'd0, 32'd16, 0);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
